adc_scan_seq: RTL and testbench

Scan sequencer for the SPI ADC datapath in the demodulator. It steps the SPI master through a configurable set of ADC input channels on a fixed period, converting each channel in turn. It accounts for the ADC's one-frame pipeline: the address sent in frame n produces the result returned in frame n+1. Each result is tagged with its own channel and presented to the downstream DSP.

---
 rtl/adc_scan_seq.sv | 170 +++++++++++++++++
 tb/tb_adc_scan_seq.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_seq.sv
// Scan sequencer: steps an SPI ADC through the channels in ch_mask and tags each pipelined result with its channel.
// Optional SPI watchdog with `define ADC_SCAN_TIMEOUT_EN (default build: no watchdog, err tied low).
module adc_scan_seq #(
  parameter int DW = 12,
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [7:0]    ch_mask,
  input  logic [PW-1:0] period,
  output logic          spi_go,
  output logic [2:0]    spi_ch,
  input  logic          spi_done,
  input  logic [DW-1:0] spi_data,
  output logic          smp_valid,
  output logic [2:0]    smp_ch,
  output logic [DW-1:0] smp_data,
  output logic          scan_done,
  output logic          overrun,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, WAIT_TICK, ISSUE, WAIT_DONE} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] cnt;
  logic          tick;
  logic [7:0]    rem;
  logic [2:0]    c0, prev_ch;
  logic          first, dummy, abort;
  logic          scan_start, emit, next_frame, timeout;
  logic          busy;

  function automatic logic [2:0] lowest(input logic [7:0] m);
    lowest = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) lowest = i[2:0];
    end
  endfunction

  assign busy   = (state == ISSUE) || (state == WAIT_DONE);
  assign tick   = en && ((period == '0) || (cnt == period - PW'(1)));
  assign spi_go = (state == ISSUE);

`ifdef ADC_SCAN_TIMEOUT_EN
  logic [9:0] wd;

  // wd equals the number of cycles elapsed since spi_go
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd <= 10'd0;
    end else if (state == ISSUE) begin
      wd <= 10'd1;
    end else if (state == WAIT_DONE) begin
      wd <= wd + 10'd1;
    end
  end

  assign timeout = (state == WAIT_DONE) && !spi_done && (wd == 10'd1022);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    scan_start = 1'b0;
    emit       = 1'b0;
    next_frame = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          scan_start = 1'b1;
          state_nxt  = (ch_mask == 8'd0) ? WAIT_TICK : ISSUE;
        end
      end
      WAIT_TICK: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (tick) begin
          scan_start = 1'b1;
          state_nxt  = (ch_mask == 8'd0) ? WAIT_TICK : ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (spi_done) begin
          if (abort || !en) begin
            state_nxt = IDLE;
          end else begin
            emit = !first;
            if (dummy) begin
              state_nxt = WAIT_TICK;
            end else begin
              next_frame = 1'b1;
              state_nxt  = ISSUE;
            end
          end
        end else if (timeout) begin
          state_nxt = WAIT_TICK;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      rem       <= 8'd0;
      c0        <= 3'd0;
      prev_ch   <= 3'd0;
      spi_ch    <= 3'd0;
      first     <= 1'b0;
      dummy     <= 1'b0;
      abort     <= 1'b0;
      smp_valid <= 1'b0;
      smp_ch    <= 3'd0;
      smp_data  <= '0;
      scan_done <= 1'b0;
      overrun   <= 1'b0;
      err       <= 1'b0;
    end else begin
      smp_valid <= emit;
      scan_done <= emit && dummy;
      if (emit) begin
        smp_ch   <= prev_ch;
        smp_data <= spi_data;
      end

      // the counter wraps on its own tick so ticks stay periodic across overruns
      if (!en || scan_start || tick) cnt <= '0;
      else                           cnt <= cnt + PW'(1);

      if (scan_start) begin
        rem    <= ch_mask & ~(8'd1 << lowest(ch_mask));
        c0     <= lowest(ch_mask);
        spi_ch <= lowest(ch_mask);
        first  <= 1'b1;
        dummy  <= 1'b0;
        abort  <= 1'b0;
      end else if (next_frame) begin
        prev_ch <= spi_ch;
        first   <= 1'b0;
        if (rem != 8'd0) begin
          spi_ch <= lowest(rem);
          rem    <= rem & ~(8'd1 << lowest(rem));
        end else begin
          // extra frame re-addresses c0 only to flush the ADC pipeline
          spi_ch <= c0;
          dummy  <= 1'b1;
        end
      end

      if (busy && !en) abort <= 1'b1;

      if (!en)                                  overrun <= 1'b0;
      else if (tick && busy && period != '0)    overrun <= 1'b1;

      if (!en)          err <= 1'b0;
      else if (timeout) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adc_scan_seq.sv
// Scoreboard bench for adc_scan_seq: SPI pipeline model, address checks and sample monitor.
module tb_adc_scan_seq;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [7:0]  ch_mask;
  logic [15:0] period;
  logic        spi_go;
  logic [2:0]  spi_ch;
  logic        spi_done;
  logic [11:0] spi_data;
  logic        smp_valid;
  logic [2:0]  smp_ch;
  logic [11:0] smp_data;
  logic        scan_done, overrun, err;

  adc_scan_seq #(.DW(12), .PW(16)) dut (
    .clk(clk), .rst(rst), .en(en), .ch_mask(ch_mask), .period(period),
    .spi_go(spi_go), .spi_ch(spi_ch), .spi_done(spi_done), .spi_data(spi_data),
    .smp_valid(smp_valid), .smp_ch(smp_ch), .smp_data(smp_data),
    .scan_done(scan_done), .overrun(overrun), .err(err)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  ch;
    logic [11:0] dat;
    logic        sd;
  } smp_t;

  smp_t exp_smp[$];
  int   exp_addr[$];
  int   go_cyc[$];
  int   sd_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   frame_len = 1;
  bit   withhold = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_s(input int ch, input int dat, input bit sd);
    smp_t s;
    s.ch  = ch[2:0];
    s.dat = dat[11:0];
    s.sd  = sd;
    exp_smp.push_back(s);
  endtask

  task automatic wait_sb(input int budget);
    int i;
    for (i = 0; i < budget && exp_smp.size() != 0; i++) step();
    if (exp_smp.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_drain: %0d samples outstanding after %0d cycles", exp_smp.size(), budget);
    end
  endtask

  task automatic wait_gos(input int n, input int budget);
    int i;
    for (i = 0; i < budget && go_cyc.size() < n; i++) step();
    if (go_cyc.size() < n) begin
      checks++;
      errors++;
      $display("FAIL go_wait: got %0d spi_go, expected %0d", go_cyc.size(), n);
    end
  endtask

  function automatic int go_at(input int idx);
    if (go_cyc.size() > idx) return go_cyc[idx];
    return -1;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // SPI ADC model: each frame returns the value for the address of the previous frame
  initial begin
    int  left, cur_addr, last_addr, e;
    bit  busy;
    busy = 1'b0; left = 0; cur_addr = 0; last_addr = 0;
    spi_done = 1'b0;
    spi_data = 12'd0;
    forever begin
      step();
      spi_done = 1'b0;
      if (rst) begin
        busy = 1'b0;
      end else begin
        if (busy) begin
          left--;
          if (left == 0) begin
            spi_done  = !withhold;
            spi_data  = 12'(last_addr * 100);
            last_addr = cur_addr;
            busy      = 1'b0;
          end
        end
        if (spi_go) begin
          cur_addr = int'(spi_ch);
          go_cyc.push_back(cyc);
          if (exp_addr.size() > 0) begin
            e = exp_addr.pop_front();
            chk("spi_ch", cur_addr, e);
          end
          busy = 1'b1;
          left = frame_len;
        end
      end
    end
  end

  initial begin
    smp_t s;
    forever begin
      @(negedge clk);
      if (smp_valid || scan_done) begin
        if (scan_done) sd_cyc.push_back(cyc);
        if (exp_smp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_smp: smp_valid=%0d scan_done=%0d ch=%0d data=%0d, expected none",
                   smp_valid, scan_done, smp_ch, smp_data);
        end else begin
          s = exp_smp.pop_front();
          chk("smp_valid", int'(smp_valid), 1);
          chk("smp_ch", int'(smp_ch), int'(s.ch));
          chk("smp_data", int'(smp_data), int'(s.dat));
          chk("scan_done", int'(scan_done), int'(s.sd));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int t, g;
    rst = 1'b1; en = 1'b0; ch_mask = 8'd0; period = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_spi_go", int'(spi_go), 0);
    chk("rst_spi_ch", int'(spi_ch), 0);
    chk("rst_smp_valid", int'(smp_valid), 0);
    chk("rst_scan_done", int'(scan_done), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_err", int'(err), 0);
    rst = 1'b0;
    step();

    // mask 0101, period 200
    ch_mask = 8'h05; period = 16'd200; frame_len = 3;
    go_cyc.delete(); exp_addr.delete();
    repeat (2) begin
      exp_addr.push_back(0); exp_addr.push_back(2); exp_addr.push_back(0);
      push_s(0, 0, 1'b0);
      push_s(2, 200, 1'b1);
    end
    t = cyc;
    en = 1'b1;
    wait_gos(4, 400);
    chk("first_go_latency", go_at(0), t + 1);
    chk("period_200", go_at(3) - go_at(0), 200);
    wait_sb(100);
    chk("overrun_p200", int'(overrun), 0);
    en = 1'b0;
    repeat (5) step();

    // all channels, back-to-back scans
    ch_mask = 8'hFF; period = 16'd0; frame_len = 2;
    go_cyc.delete(); sd_cyc.delete(); exp_addr.delete();
    repeat (2) begin
      for (int i = 0; i < 8; i++) exp_addr.push_back(i);
      exp_addr.push_back(0);
      for (int i = 0; i < 8; i++) push_s(i, i * 100, i == 7);
    end
    en = 1'b1;
    wait_sb(200);
    chk("overrun_p0", int'(overrun), 0);
    en = 1'b0;
    repeat (10) step();
    chk("nine_frames", go_at(9) - go_at(0), 28);
    chk("back_to_back", go_at(9), (sd_cyc.size() > 0) ? sd_cyc[0] + 1 : -1);
    exp_addr.delete();

    // frame longer than period
    ch_mask = 8'h01; period = 16'd10; frame_len = 50;
    go_cyc.delete();
    repeat (4) exp_addr.push_back(0);
    repeat (2) push_s(0, 0, 1'b1);
    en = 1'b1;
    wait_sb(400);
    chk("overrun_set", int'(overrun), 1);
    en = 1'b0;
    step(); step();
    chk("overrun_clear", int'(overrun), 0);
    repeat (60) step();
    exp_addr.delete();

    // en dropped during frame 2
    ch_mask = 8'h0F; period = 16'd500; frame_len = 20;
    go_cyc.delete();
    exp_addr.push_back(0); exp_addr.push_back(1); exp_addr.push_back(2);
    push_s(0, 0, 1'b0);
    en = 1'b1;
    wait_gos(3, 200);
    en = 1'b0;
    repeat (60) step();
    chk("abort_go_count", go_cyc.size(), 3);
    chk("abort_sb_empty", exp_smp.size(), 0);
    exp_addr.push_back(0);
    t = cyc;
    en = 1'b1;
    step(); step();
    chk("idle_restart", go_at(3), t + 1);
    en = 1'b0;
    repeat (30) step();
    exp_addr.delete();

    // reset while in WAIT_DONE
    ch_mask = 8'h08; period = 16'd3; frame_len = 30;
    go_cyc.delete();
    exp_addr.push_back(3);
    en = 1'b1;
    wait_gos(1, 20);
    repeat (5) step();
    chk("pre_rst_spi_ch", int'(spi_ch), 3);
    chk("pre_rst_overrun", int'(overrun), 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_spi_go", int'(spi_go), 0);
    chk("async_rst_spi_ch", int'(spi_ch), 0);
    chk("async_rst_overrun", int'(overrun), 0);
    chk("async_rst_smp", int'({smp_valid, scan_done, smp_ch, smp_data}), 0);
    step(); step();
    exp_addr.delete();
    exp_addr.push_back(3);
    go_cyc.delete();
    t = cyc;
    rst = 1'b0;
    step(); step();
    chk("post_rst_go", go_at(0), t + 1);
    en = 1'b0;
    repeat (40) step();
    exp_addr.delete();

`ifdef ADC_SCAN_TIMEOUT_EN
    ch_mask = 8'h01; period = 16'd2000; frame_len = 5; withhold = 1'b1;
    go_cyc.delete();
    exp_addr.push_back(0); exp_addr.push_back(0);
    t = cyc;
    g = t + 1;
    en = 1'b1;
    while (cyc < g + 1022) step();
    chk("timeout_go", go_at(0), g);
    chk("err_before", int'(err), 0);
    step();
    chk("err_set", int'(err), 1);
    wait_gos(2, 1100);
    chk("timeout_next_tick", go_at(1), g + 2000);
    en = 1'b0;
    withhold = 1'b0;
    repeat (10) step();
`else
    g = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
